// File: rtl/alu_pkg.sv
// alu_pkg: op codes shared with the ALU control decoder and the exec-stage state encoding.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1110;
  typedef enum logic [1:0] {IDLE, MUL, FULL} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, low word only, fixed WIDTH-iteration latency.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]    cnt_q;
  // prod is the accumulator after the current iteration, so the last one can be written out directly
  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done = run && cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (run) begin
      acc_q    <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshake, registered result/flags, iterative multiply.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);
  state_e           state_q;
  logic             accept, is_mul, mul_done, ovf_d, ill_d;
  logic [WIDTH-1:0] sum, diff, res_d, mul_prod;
  assign in_ready  = rstn && (state_q == IDLE || (state_q == FULL && out_ready));
  assign out_valid = state_q == FULL;
  assign accept    = in_valid && in_ready;
  assign is_mul    = MUL_EN && operation == ALU_MUL;
  assign sum       = src_a + src_b;
  assign diff      = src_a - src_b;
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    ill_d = 1'b0;
    case (operation)
      ALU_AND: res_d = src_a & src_b;
      ALU_OR:  res_d = src_a | src_b;
      ALU_ADD: begin
        res_d = sum;
        ovf_d = src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1];
      end
      ALU_SUB: begin
        res_d = diff;
        ovf_d = src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1];
      end
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_NOR: res_d = ~(src_a | src_b);
      default: ill_d = 1'b1;
    endcase
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rstn  (rstn),
    .start (accept && is_mul),
    .run   (state_q == MUL),
    .a     (src_a),
    .b     (src_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (state_q == MUL) begin
      if (mul_done) begin
        state_q  <= FULL;
        result   <= mul_prod;
        zero     <= mul_prod == '0;
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end else if (accept && is_mul) begin
      state_q <= MUL;
    end else if (accept) begin
      state_q  <= FULL;
      result   <= res_d;
      zero     <= res_d == '0;
      overflow <= ovf_d;
      illegal  <= ill_d;
    end else if (state_q == FULL && out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec plus a MUL_EN=0 instance for the illegal-multiply case.
module tb_alu_exec;
  import alu_pkg::*;
  typedef struct packed {
    logic [31:0] r;
    logic        z, v, i;
  } exp_t;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [3:0]  operation = 4'b0;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic        zero, overflow, illegal;
  logic        v2 = 1'b0, r2, ov2, z2, o2, i2;
  logic [31:0] res2;
  exp_t        q[$];
  exp_t        mon_e;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_exec #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );
  alu_exec #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rstn(rstn), .in_valid(v2), .in_ready(r2),
    .operation(operation), .src_a(src_a), .src_b(src_b),
    .out_valid(ov2), .out_ready(1'b1), .result(res2),
    .zero(z2), .overflow(o2), .illegal(i2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        s = {a[31], a} + {b[31], b};
        e.r = s[31:0];
        e.v = s[32] != s[31];
      end
      4'b0110: begin
        s = {a[31], a} - {b[31], b};
        e.r = s[31:0];
        e.v = s[32] != s[31];
      end
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: e.r = ~(a | b);
      4'b1110: e.r = a * b;
      default: e.i = 1'b1;
    endcase
    e.z = e.r == 32'd0;
    return e;
  endfunction
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) chk("accept_timeout", 32'd1, 32'd0);
    else q.push_back(model(op, a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("result", result, mon_e.r);
        chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
        chk("overflow", {31'd0, overflow}, {31'd0, mon_e.v});
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.i});
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    #12;
    chk("rst_outs", {out_valid, in_ready, zero, overflow, illegal}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    send(ALU_SUB, 32'd5, 32'd5);
    chk("no_bubble", {31'd0, in_ready}, 32'd1);
    send(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    send(ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
    send(ALU_SUB, 32'h8000_0000, 32'h0000_0001);
    send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    send(ALU_OR,  32'h1200_0034, 32'h0045_6000);
    send(ALU_MUL, 32'h0001_0003, 32'h0002_0005);
    bad = 0;
    for (int c = 1; c <= 31; c++) begin
      in_valid  = c < 31;
      operation = ALU_ADD;
      src_a     = 32'd1;
      src_b     = 32'd1;
      @(posedge clk) #1;
      if (out_valid || in_ready) bad++;
    end
    in_valid = 1'b0;
    chk("mul_busy", bad, 0);
    @(posedge clk) #1;
    chk("mul_latency", {31'd0, out_valid}, 32'd1);
    @(posedge clk) #1;
    out_ready = 1'b0;
    send(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk) #1;
      if (result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk) #1;
    chk("transfer_idle", {30'd0, out_valid, in_ready}, 32'd1);
    send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    send(4'b0011, 32'h0000_0001, 32'h0000_0002);
    @(negedge clk);
    operation = ALU_MUL;
    src_a     = 32'd3;
    src_b     = 32'd4;
    v2        = 1'b1;
    @(posedge clk) #1;
    v2 = 1'b0;
    chk("nomul_illegal", {29'd0, ov2, i2, z2}, 32'h7);
    chk("nomul_result", res2, 32'd0);
    send(ALU_ADD, 32'd10, 32'd20);
    @(posedge clk) #1;
    send(ALU_MUL, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    q.delete();
    #1;
    chk("rst_mul_outs", {out_valid, in_ready, zero, overflow, illegal}, 32'd0);
    chk("rst_mul_result", result, 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;
    chk("ready_after_rst2", {31'd0, in_ready}, 32'd1);
    send(ALU_ADD, 32'd2, 32'd3);
    chk("add_after_rst", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU directly downstream of the ALU control decoder. Consumes its 4-bit operation code plus two operands, produces a registered result with zero/overflow flags.
- Uses a valid/ready handshake on both sides.
- Single-cycle ops complete with 1-cycle latency. Op 1110 (the ALUOp=11 slot) is an iterative unsigned multiply, low word only, that holds the unit busy for WIDTH cycles.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- MUL_EN, 1, 1 = op 1110 is multiply; 0 = op 1110 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operation/operands valid.
- in_ready  out  1  unit can accept this cycle.
- operation  in  4  op code from ALU control.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (add/sub only).
- illegal  out  1  op code was not recognised.

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT: signed A<B gives 1, else 0, zero-extended.
  - 1100 NOR.
  - 1110 MUL: (A*B) mod 2^WIDTH, unsigned.
  - Anything else, including 1111: result 0, illegal=1, overflow=0, zero=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or differ (SUB), and result sign differs from src_a. Otherwise 0.
  - zero is computed from the value written into result, and registered with it.
- Reset (rstn low, async): state IDLE; out_valid=0, result=0, zero=0, overflow=0, illegal=0, in_ready=0. A multiply in progress is discarded with no output. in_ready goes high the first cycle after release.
- States:
  - IDLE: no result held.
  - MUL: iterating.
  - FULL: result held, out_valid=1.
- Handshake:
  - in_ready = (state==IDLE) or (state==FULL and out_ready). Combinational, with no path from in_valid.
  - Accept = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - In FULL with accept and transfer in the same cycle, the old result leaves and the new op is taken (back-to-back, no bubble).
  - In FULL without transfer, all output registers hold stable. operation/src_a/src_b are ignored.
- Single-cycle op accepted at edge N: result/flags written and out_valid=1 after edge N; state FULL.
- MUL accepted at edge N:
  - Latch the multiplicand and multiplier, clear the accumulator, set counter=0, state MUL, out_valid=0.
  - Each edge: if multiplier LSB=1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment counter.
  - After the WIDTH-th iteration (edge N+WIDTH), write result, set out_valid=1, state FULL.
  - in_ready=0 throughout MUL, and in_valid is ignored.
- Accept in FULL without transfer is impossible (in_ready=0).
- Transfer in FULL without accept → IDLE, out_valid=0. result/flags keep their last value.
- No early termination on a zero multiplier: latency is always WIDTH.

Decomposition:
- Shared package alu_pkg: ALU_AND/OR/ADD/SUB/SLT/NOR/MUL 4-bit op constants (the same constants the ALU control drives), and the state enum {IDLE, MUL, FULL}.
- One natural sub-module: alu_mul_iter (shift-add datapath with start/done, WIDTH-cycle latency). The top module holds the handshake FSM, the combinational ALU and the output registers.

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001 → one cycle later result=0x80000000, overflow=1, zero=0, illegal=0.
- SUB 5-5 with out_ready held 1, followed immediately by SLT 0xFFFFFFFF vs 0x00000001 → result=0 with zero=1, then result=1 on the next cycle; in_ready stays 1 (no bubble).
- MUL 0x0001_0003 × 0x0002_0005 → in_ready=0 for 32 cycles, out_valid on edge N+32, result=0x000B_000F; a second op driven during MUL is not accepted.
- out_ready=0 for 5 cycles after a NOR 0xF0F0F0F0,0x0F0F0F0F result (=0) → result/zero stable, in_ready=0; then out_ready=1 → transfer, state IDLE.
- Op 1111 and op 0011 → result=0, illegal=1, zero=1; with MUL_EN=0, op 1110 → illegal=1.
- Assert rstn low at MUL cycle 10 → out_valid=0 immediately, all outputs zero; after release a new ADD 2+3 returns 5 with 1-cycle latency.
